// File: rtl/serial_magnitude_comparator.sv
// Bit-serial, MSB-first magnitude comparator.
// Takes one (a_bit, b_bit) pair per accepted beat. After WIDTH pairs it
// updates the registered, one-hot relation flags and pulses done.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a comparison (honoured in IDLE or DONE)
//   bit_valid, bit_ready  per-beat handshake; bit_ready is high only in COMPARE
//   a_bit, b_bit          operand bits, MSB first
//   busy                  high while comparing
//   done                  one-cycle pulse when the result flags update
//   a_greater_b, a_equal_b, a_lower_b   last completed result, one-hot
module serial_magnitude_comparator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  output logic bit_ready,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic a_greater_b,
  output logic a_equal_b,
  output logic a_lower_b
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             wgt_q, wgt_d;
  logic             wlt_q, wlt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  // Next-state, working-register and result logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    wgt_d     = wgt_q;
    wlt_d     = wlt_q;
    gt_d      = gt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d   = COMPARE;
          cnt_d     = '0;
          decided_d = 1'b0;
          wgt_d     = 1'b0;
          wlt_d     = 1'b0;
        end
      end
      COMPARE: begin
        if (bit_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          // First differing bit (MSB first) settles the relation
          if (!decided_q && (a_bit != b_bit)) begin
            decided_d = 1'b1;
            wgt_d     = a_bit;
            wlt_d     = b_bit;
          end
          // Result uses the updated working bits so a deciding last bit counts
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
            gt_d    = wgt_d;
            lt_d    = wlt_d;
            eq_d    = ~wgt_d & ~wlt_d;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == COMPARE);
    ready_d = (state_d == COMPARE);
    done_d  = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      wgt_q     <= 1'b0;
      wlt_q     <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b1;
      lt_q      <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      wgt_q     <= wgt_d;
      wlt_q     <= wlt_d;
      gt_q      <= gt_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign bit_ready   = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign a_greater_b = gt_q;
  assign a_equal_b   = eq_q;
  assign a_lower_b   = lt_q;

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
Bit-serial, MSB-first magnitude comparator. It consumes one (a_bit, b_bit) pair per accepted handshake and produces the registered relation flags a_greater_b / a_equal_b / a_lower_b after WIDTH pairs. It is the sequential, streaming counterpart of the team's combinational single-bit comparator. It sits on the receive side of serial links that deliver operands one bit per beat.

Parameters:
WIDTH, 8, number of bit pairs per comparison (legal range 1..64)
CNT_W, $clog2(WIDTH+1), width of internal bit counter (derived; not overridden)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a new comparison; sampled only in IDLE or DONE
bit_valid  input  1  a_bit/b_bit pair is valid this cycle
bit_ready  output  1  block accepts a pair this cycle (high only in COMPARE)
a_bit  input  1  current bit of operand A, MSB first
b_bit  input  1  current bit of operand B, MSB first
busy  output  1  high in COMPARE
done  output  1  single-cycle pulse when result updates
a_greater_b  output  1  registered result A > B
a_equal_b  output  1  registered result A == B
a_lower_b  output  1  registered result A < B

Behaviour:
- Reset (async assert, sync-release by upstream): state=IDLE, counter=0, decided=0, busy=0, bit_ready=0, done=0, a_greater_b=0, a_equal_b=1, a_lower_b=0.
- Reset mid-comparison: partial result discarded; outputs return to reset values immediately.
- FSM states: IDLE, COMPARE, DONE.
- IDLE: start=1 -> COMPARE next edge; clears counter, decided flag, working gt/lt.
- COMPARE: bit_ready=1, busy=1. Accept = bit_valid & bit_ready. On each accept, counter++.
  - If decided=0 and a_bit!=b_bit: set decided=1, working gt=a_bit, lt=b_bit.
  - Once decided, later bits are consumed but ignored (first differing MSB wins).
  - bit_valid=0 stalls indefinitely with no timeout; counter holds.
  - On the accept where counter reaches WIDTH-1 -> DONE next edge.
- DONE: lasts exactly one cycle. done=1, bit_ready=0, busy=0.
  - Result flags load from working regs on the edge entering DONE: gt, lt, equal = ~gt & ~lt.
  - start=1 in DONE -> COMPARE next edge (back-to-back); otherwise -> IDLE.
- Result flags are always one-hot. They hold the last completed result through IDLE and a following COMPARE, and change only on entry to DONE.
- start while in COMPARE is ignored. bit_valid in IDLE/DONE is ignored (no accept, no count).
- Latency: start edge -> bit_ready high next cycle. With no stalls, done asserts WIDTH+1 cycles after start is sampled. Minimum issue interval is WIDTH+1 cycles.
- WIDTH=1 is legal: a single accept goes straight to DONE.

Test Plan:
- Reset then idle, no start -> flags 0/1/0, busy=0, bit_ready=0, done never pulses.
- WIDTH=8, A=0xA5, B=0x5A, bit_valid held high -> done pulse at cycle 9 after start; gt=1, eq=0, lt=0.
- A=0x01, B=0x80 with bit_valid low for 3 cycles after bit 2 -> done delayed by 3 cycles; lt=1. Then A=B=0x3C back-to-back (start asserted during DONE) -> eq=1; previous lt=1 held until the second done.
- A=0x7F, B=0x7E (difference only in LSB) -> gt=1. start pulsed at bit 4 -> ignored, count unaffected.
- rst_n asserted after 4 accepted bits of A=0xFF, B=0x00 -> outputs immediately 0/1/0, state IDLE. A new start with A=0x00, B=0xFF -> lt=1.
- bit_valid=1 with random bits while in IDLE for 10 cycles, then start -> no pairs consumed early; the first pair accepted is the one presented in the first COMPARE cycle.
